// File: rtl/adiabatic_pc_sequencer.sv
// Four-phase power-clock sequencer for the adiabatic ALU array: per-stage clkpos/clkneg
// enables, one-entry operand buffer, frame-aligned launch and stage-3 hold-interval capture.

module adiabatic_pc_stage #(
  parameter logic [1:0] K = 2'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] q_next,
  output logic       pc_pos,
  output logic       pc_neg
);
  logic       started;
  logic       started_next;
  logic [1:0] st_next;
  logic       pos_next;

  // Stage k stays dark until the phase counter first reaches k.
  assign started_next = started | (q_next == K);
  assign st_next      = q_next - K;
  assign pos_next     = started_next & ~st_next[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started <= 1'b0;
      pc_pos  <= 1'b0;
      pc_neg  <= 1'b1;
    end else begin
      started <= started_next;
      pc_pos  <= pos_next;
      pc_neg  <= ~pos_next;
    end
  end
endmodule

module adiabatic_pc_sequencer #(
  parameter int W   = 8,
  parameter int DIV = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic [W-1:0] op_a,
  output logic [W-1:0] op_b,
  input  logic [W-1:0] res_in,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic [3:0]   pc_pos,
  output logic [3:0]   pc_neg,
  output logic         frame_start
);
  localparam int            SW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [SW-1:0] SUB_MAX = SW'(DIV - 1);

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
  } opnd_t;

  logic [SW-1:0] sub, sub_next;
  logic [1:0]    q, q_next;
  logic          wrap, boundary;
  logic          buf_full, buf_full_next;
  opnd_t         bufd;
  logic          accept, launch, capture;
  logic [1:0]    vld_pipe;
  logic          tag1_next;

  assign wrap     = (sub == SUB_MAX);
  assign sub_next = wrap ? '0 : sub + SW'(1);
  assign q_next   = wrap ? q + 2'd1 : q;
  assign boundary = wrap && (q == 2'd3);

  assign accept        = in_valid && in_ready;
  assign launch        = boundary && buf_full;
  assign buf_full_next = launch ? 1'b0 : (accept ? 1'b1 : buf_full);

  // Capture is qualified on next-state values so DIV=1 captures on the boundary edge itself.
  assign tag1_next = boundary ? vld_pipe[0] : vld_pipe[1];
  assign capture   = (q_next == 2'd0) && (sub_next == SUB_MAX) && tag1_next;

  for (genvar k = 0; k < 4; k++) begin : g_stage
    adiabatic_pc_stage #(.K(2'(k))) u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .q_next (q_next),
      .pc_pos (pc_pos[k]),
      .pc_neg (pc_neg[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub         <= SUB_MAX;
      q           <= 2'd3;
      buf_full    <= 1'b0;
      bufd        <= '0;
      in_ready    <= 1'b0;
      op_a        <= '0;
      op_b        <= '0;
      vld_pipe    <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      frame_start <= 1'b0;
    end else begin
      sub         <= sub_next;
      q           <= q_next;
      buf_full    <= buf_full_next;
      in_ready    <= ~buf_full_next;
      frame_start <= boundary;
      out_valid   <= capture;
      if (accept)
        bufd <= '{a: in_a, b: in_b};
      if (boundary)
        vld_pipe <= {vld_pipe[0], buf_full};
      if (launch) begin
        op_a <= bufd.a;
        op_b <= bufd.b;
      end
      if (capture)
        out_data <= res_in;
    end
  end
endmodule

// File: tb/tb_adiabatic_pc_sequencer.sv
// Bench for adiabatic_pc_sequencer: DIV=4 and DIV=1 instances run side by side against a
// frame-timeline reference model; the cell array is modelled as a fixed-delay XOR.

module tb_adiabatic_pc_sequencer;
  localparam int W  = 8;
  localparam int NI = 2;
  localparam int H  = 64;

  logic clk = 1'b0;
  logic rst_n;
  logic         iv  [NI];
  logic [W-1:0] ia  [NI];
  logic [W-1:0] ib  [NI];
  logic [W-1:0] res [NI];
  logic         rdy [NI];
  logic         ov  [NI];
  logic         fs  [NI];
  logic [W-1:0] oa  [NI];
  logic [W-1:0] ob  [NI];
  logic [W-1:0] od  [NI];
  logic [3:0]   pp  [NI];
  logic [3:0]   pn  [NI];

  always #5 clk = ~clk;

  adiabatic_pc_sequencer #(.W(W), .DIV(4)) u_div4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(rdy[0]),
    .in_a(ia[0]), .in_b(ib[0]), .op_a(oa[0]), .op_b(ob[0]), .res_in(res[0]),
    .out_valid(ov[0]), .out_data(od[0]), .pc_pos(pp[0]), .pc_neg(pn[0]),
    .frame_start(fs[0])
  );

  adiabatic_pc_sequencer #(.W(W), .DIV(1)) u_div1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(rdy[1]),
    .in_a(ia[1]), .in_b(ib[1]), .op_a(oa[1]), .op_b(ob[1]), .res_in(res[1]),
    .out_valid(ov[1]), .out_data(od[1]), .pc_pos(pp[1]), .pc_neg(pn[1]),
    .frame_start(fs[1])
  );

  // Cell array: result of a^b appears 3*DIV cycles after it is presented.
  logic [W-1:0] dly4 [12];
  logic [W-1:0] dly1 [3];
  always @(posedge clk) begin
    dly4[0] <= oa[0] ^ ob[0];
    for (int m = 1; m < 12; m++) dly4[m] <= dly4[m-1];
    dly1[0] <= oa[1] ^ ob[1];
    for (int m = 1; m < 3; m++) dly1[m] <= dly1[m-1];
  end
  assign res[0] = dly4[11];
  assign res[1] = dly1[2];

  int           n    [NI];
  bit           mfull[NI], mrdy[NI], mov[NI], macc[NI];
  logic [W-1:0] ma [NI], mb [NI], moa [NI], mob [NI], mod [NI];
  logic [W:0]   hist [NI][H];
  logic [2*W-1:0] q0 [$];
  logic [2*W-1:0] q1 [$];
  bit           pv [NI];
  logic [W-1:0] pa [NI], pb [NI];
  bit           prst;
  bit           gaps;
  int           n_assert = 0;
  int           n_fail   = 0;

  function automatic int divof(int i);
    return (i == 0) ? 4 : 1;
  endfunction

  task automatic chk(string tag, int i, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[div%0d] observed=%h expected=%h", tag, divof(i), obs, exp);
    end
  endtask

  // Interval index since release decides which stages are lit.
  function automatic logic [3:0] exp_pc(int i);
    int d, ix, qq;
    logic [3:0] r;
    r = 4'b0000;
    if (n[i] == 0) return r;
    d  = divof(i);
    ix = (n[i] - 1) / d;
    qq = ix % 4;
    for (int k = 0; k < 4; k++)
      r[k] = (ix >= k) && (((qq - k + 4) % 4) < 2);
    return r;
  endfunction

  task automatic model_reset(int i);
    n[i] = 0; mfull[i] = 0; mrdy[i] = 0; mov[i] = 0; macc[i] = 0;
    moa[i] = '0; mob[i] = '0; mod[i] = '0;
  endtask

  task automatic model_update(int i);
    int d, l;
    bit bnd;
    d = divof(i);
    l = 5 * d - 1;
    n[i]++;
    bnd = ((n[i] - 1) % (4 * d)) == 0;
    macc[i] = pv[i] && mrdy[i];
    hist[i][n[i] % H] = '0;
    if (bnd && mfull[i]) begin
      moa[i] = ma[i];
      mob[i] = mb[i];
      mfull[i] = 0;
      hist[i][n[i] % H] = {1'b1, ma[i] ^ mb[i]};
    end
    if (macc[i]) begin
      mfull[i] = 1;
      ma[i] = pa[i];
      mb[i] = pb[i];
    end
    mrdy[i] = !mfull[i];
    mov[i] = 0;
    if (n[i] > l && hist[i][(n[i] - l) % H][W]) begin
      mov[i] = 1;
      mod[i] = hist[i][(n[i] - l) % H][W-1:0];
    end
  endtask

  task automatic check_all(int i);
    logic [3:0] e;
    bit efs;
    e   = exp_pc(i);
    efs = (n[i] > 0) && (((n[i] - 1) % (4 * divof(i))) == 0);
    chk("pc_pos", i, pp[i], e);
    chk("pc_neg", i, pn[i], 4'(~e));
    chk("frame_start", i, fs[i], efs);
    chk("in_ready", i, rdy[i], mrdy[i]);
    chk("op_a", i, oa[i], moa[i]);
    chk("op_b", i, ob[i], mob[i]);
    chk("out_valid", i, ov[i], mov[i]);
    chk("out_data", i, od[i], mod[i]);
  endtask

  task automatic step();
    iv[0] = (q0.size() > 0) && (!gaps || $urandom_range(0, 3) != 0);
    if (q0.size() > 0) {ia[0], ib[0]} = q0[0];
    else               {ia[0], ib[0]} = 16'($urandom);
    iv[1] = (q1.size() > 0) && (!gaps || $urandom_range(0, 3) != 0);
    if (q1.size() > 0) {ia[1], ib[1]} = q1[0];
    else               {ia[1], ib[1]} = 16'($urandom);
    prst = rst_n;
    for (int i = 0; i < NI; i++) begin
      pv[i] = iv[i]; pa[i] = ia[i]; pb[i] = ib[i]; macc[i] = 0;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      if (prst) model_update(i);
      check_all(i);
    end
    if (macc[0]) void'(q0.pop_front());
    if (macc[1]) void'(q1.pop_front());
  endtask

  task automatic do_reset(int cycles);
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    #1;
    for (int i = 0; i < NI; i++) begin
      model_reset(i);
      check_all(i);
    end
    repeat (cycles) step();
    rst_n = 1'b1;
  endtask

  task automatic push_both(logic [W-1:0] a, logic [W-1:0] b);
    q0.push_back({a, b});
    q1.push_back({a, b});
  endtask

  initial begin
    gaps  = 0;
    rst_n = 1'b1;
    for (int i = 0; i < NI; i++) begin
      iv[i] = 1'b0; ia[i] = '0; ib[i] = '0;
      model_reset(i);
    end
    #1;
    do_reset(3);

    // Startup: pc_pos ramp and frame_start cadence with no traffic.
    repeat (40) step();

    // Single operation.
    push_both(8'h5A, 8'h0F);
    repeat (40) step();

    // Back-to-back with valid held high, then three idle frames.
    push_both(8'h01, 8'hF0);
    push_both(8'h02, 8'hF0);
    push_both(8'h03, 8'hF0);
    repeat (100) step();
    repeat (48) step();

    // Reset eight cycles after a launch on the DIV=4 instance.
    push_both(8'hC3, 8'h3C);
    for (int t = 0; t < 64 && !hist[0][n[0] % H][W]; t++) step();
    chk("launch_wait", 0, 32'(hist[0][n[0] % H][W]), 32'd1);
    repeat (8) step();
    do_reset(2);
    repeat (40) step();

    // Randomized operands with random valid gaps.
    gaps = 1;
    for (int k = 0; k < 40; k++) begin
      q0.push_back(16'($urandom));
      q1.push_back(16'($urandom));
    end
    for (int t = 0; t < 4000 && (q0.size() > 0 || q1.size() > 0); t++) step();
    chk("drain", 0, 32'(q0.size() + q1.size()), 32'd0);
    repeat (40) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/adiabatic_pc_sequencer.md
# adiabatic_pc_sequencer

Four-phase power-clock sequencer and operand launch/capture stage for the MIPS25 adiabatic ALU datapath. It generates the per-stage `clkpos`/`clkneg` power-clock enables that drive cascaded adiabatic cells such as the conditional inverter slices. It also launches operands into the first adiabatic stage and captures the result from the fourth stage during that stage's hold interval. It sits directly upstream of the adiabatic cell array, as its operand and power-clock source, and directly downstream of it, as its result sink.

## Interface
- `W`, 8: operand/result width (number of parallel adiabatic bit slices).
- `DIV`, 4: system clock cycles per power-clock interval; legal range is 1 or greater.
- `clk`  in  1: system clock; all state updates occur on its rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `in_valid`  in  1: an operand pair is offered.
- `in_ready`  out  1: the one-entry operand buffer is empty.
- `in_a`, `in_b`  in  W: operand pair.
- `op_a`, `op_b`  out  W: operands presented to the stage-0 cell `a`/`b` inputs.
- `res_in`  in  W: output of the stage-3 cells.
- `out_valid`  out  1: one-cycle result strobe. There is no backpressure; the consumer must accept the result.
- `out_data`  out  W: captured result.
- `pc_pos`  out  4: per-stage `clkpos` enables; bit k drives stage k.
- `pc_neg`  out  4: per-stage `clkneg` enables; always `~pc_pos`.
- `frame_start`  out  1: pulse at the start of each frame.

## Operation
- **Counters.**
  - `sub` counts 0..DIV-1.
  - `q` (2 bits) advances when `sub == DIV-1` and wraps 3→0.
  - A frame is 4·DIV cycles.
  - A frame boundary is the edge at which the counters become `q=0, sub=0`.
- **Stage state.** The state of stage k is `(q−k) mod 4`: 0 = evaluate, 1 = hold, 2 = recover, 3 = wait.
- **Warm-up.**
  - `started[k]` is set at the first edge where `q_next == k`.
  - `started[k]` is cleared only by reset.
- **Power-clock outputs.**
  - `pc_pos[k]` is registered: `pc_pos[k] <= started_next[k] && state_k_next ∈ {evaluate, hold}`.
  - `pc_neg = ~pc_pos` (registered).
- **Input buffer.**
  - A transfer occurs on an edge where `in_valid && in_ready`; it sets `buf_full` and stores `in_a`/`in_b`.
  - `in_ready` is registered as `~buf_full_next`.
  - There is no bypass: an operand can launch no earlier than the frame boundary after acceptance.
- **Launch.**
  - At a frame boundary with `buf_full`: load `op_a`/`op_b` from the buffer, clear `buf_full`, and set `tag0`.
  - At a frame boundary without `buf_full`: `op_a`/`op_b` hold their previous values and `tag0` is cleared.
  - `tag1 <= tag0` at every frame boundary.
  - `op_a`/`op_b` change only at frame boundaries.
- **Capture.**
  - On the edge where `q==0 && sub==DIV-1 && tag1` (the last cycle of stage 3's hold interval): `out_data <= res_in` and `out_valid <= 1`.
  - Otherwise `out_valid <= 0` and `out_data` holds.
- **Throughput.** One operation per frame.
- **`frame_start`.** Registered; high for the one cycle following each frame boundary.

## Timing
- **Reset values** (applied immediately when `rst_n` is low):
  - Counters: `sub=DIV-1`, `q=3`, so the first edge after release is a frame boundary.
  - `started=0`, `buf_full=0`, `tag0=tag1=0`.
  - Outputs: `in_ready=0`, `op_a=op_b=0`, `out_valid=0`, `out_data=0`, `pc_pos=4'b0000`, `pc_neg=4'b1111`, `frame_start=0`.
- **First edge after release.**
  - `q=0`, `pc_pos=4'b0001`, `in_ready=1`, `frame_start=1`.
  - No launch can occur at this boundary, because the buffer is empty.
- **`pc_pos` sequence after release.** One value per interval: 0001, 0011, 0110, 1100, then steady state 1001, 0011, 0110, 1100 repeating.
- **Latency.** `out_valid` rises at launch edge + (5·DIV − 1) cycles.
- **Simultaneous accept and launch.**
  - An accept is impossible when `buf_full`, because `in_ready` is 0.
  - The buffer refills at the earliest on the edge after a launch.
- **Reset mid-operation.** Any buffered or in-flight operation is discarded. No `out_valid` may appear after release until a new operand has launched and completed.
- **`DIV = 1`.** Every edge advances `q`, and the frame is 4 cycles. Capture occurs on the frame boundary edge + 0; this is legal.

## Test plan
- **Reset and startup** (DIV=4): hold `rst_n` low, then release.
  - During reset: `pc_pos=0000`, `pc_neg=1111`, `in_ready=0`.
  - After release, `pc_pos` shows 0001 for 4 cycles, then 0011, 0110, 1100, then 1001 repeating; `frame_start` pulses every 16 cycles.
- **Single operation** (DIV=4): offer `in_a=8'h5A`, `in_b=8'h0F`; the model drives `res_in = a^b`.
  - `op_a=8'h5A` and `op_b=8'h0F` appear at the next frame boundary.
  - `out_valid` pulses once, 19 cycles after the launch edge, with `out_data=8'h55`.
- **Back-to-back operations:** offer `in_a` values 8'h01, 8'h02, 8'h03 with `in_valid` held high.
  - `in_ready` drops after each accept and returns the cycle after the launching boundary.
  - Results arrive in order, with `out_valid` pulses exactly 16 cycles apart.
- **Idle frames:** after one operation completes, hold `in_valid=0` for 3 frames.
  - `op_a`/`op_b` remain unchanged.
  - `out_valid` stays 0.
  - `pc_pos` keeps cycling.
- **Reset mid-operation:** launch an operation, then assert `rst_n` low for 2 cycles at launch + 8 cycles.
  - All outputs take their reset values immediately.
  - No `out_valid` occurs in the 40 cycles after release.
- **DIV=1:** run two back-to-back operations.
  - `pc_pos` changes every cycle.
  - `out_valid` appears 4 cycles after each launch edge.
